bias_seq_ctrl: RTL and testbench
================================

BIAS_SEQ_CTRL -- requirements
Module: bias_seq_ctrl

Interface
REQ-001 Parameter MEM_SIZE, default 16: number of bias words in the ROM, legal range >= 1.
REQ-002 Parameter DATA_WIDTH, default `coeff_width: width of each bias word.
REQ-003 Parameter REPEAT, default 4: number of full ROM passes per start, legal range >= 1.
REQ-004 ap_clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 ap_rst  in  1  reset, asynchronous, active-high.
REQ-006 ap_start  in  1  request to start one sequence; sampled only in IDLE.
REQ-007 ap_idle  out  1  high while in IDLE.
REQ-008 ap_done  out  1  one-cycle pulse when a sequence completes.
REQ-009 bias_address  out  max(1,$clog2(MEM_SIZE))  ROM read address.
REQ-010 bias_ce  out  1  ROM read enable.
REQ-011 bias_q  in  DATA_WIDTH  ROM data, valid exactly 1 cycle after bias_ce is high.
REQ-012 output_V_din  out  DATA_WIDTH  bias word to the downstream FIFO.
REQ-013 output_V_full_n  in  1  downstream FIFO not full.
REQ-014 output_V_write  out  1  write strobe; the word transfers on any cycle where write=1 and full_n=1.

Function
REQ-015 States: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN when ap_start=1; the address counter and pass counter are cleared to 0 on this transition.
REQ-017 RUN: issue reads 0..MEM_SIZE-1 in order; after MEM_SIZE-1, wrap to address 0 and increment the pass counter.
REQ-018 RUN -> DRAIN in the cycle the last read is issued (address MEM_SIZE-1, pass REPEAT-1).
REQ-019 DRAIN -> DONE when the read pipeline and the skid buffer are empty and the final write has transferred.
REQ-020 DONE: ap_done=1 for exactly one cycle, then return unconditionally to IDLE.
REQ-021 ap_start in RUN, DRAIN or DONE is ignored; a sequence is not queued.
REQ-022 ROM data enters a 2-entry FIFO skid buffer, so no word is lost or duplicated when full_n drops.
REQ-023 bias_ce=1 only in RUN, and only if buffer occupancy plus the in-flight read count is < 2.
REQ-024 output_V_write=1 whenever the buffer is non-empty, independent of full_n; the head entry is popped only on a transfer.
REQ-025 output_V_din equals the buffer head entry and stays stable while write=1 and full_n=0.
REQ-026 A simultaneous push (ROM return) and pop in the same cycle leaves occupancy unchanged.
REQ-027 Output order is exactly bias[0..MEM_SIZE-1], repeated REPEAT times, for a total of MEM_SIZE*REPEAT transfers.
REQ-028 Throughput: one transfer per cycle sustained while full_n=1; first write appears 2 cycles after the ap_start edge.
REQ-029 MEM_SIZE=1: the address stays 0; only the pass counter advances.
REQ-030 The pass counter is max(1,$clog2(REPEAT+1)) bits wide; no arithmetic overflow occurs for legal parameters.

Reset
REQ-031 While ap_rst=1, the FSM is in IDLE and ap_idle=1; ap_done, bias_ce and output_V_write are 0; counters, address and buffer occupancy are 0; output_V_din is 0.
REQ-032 Reset asserted mid-sequence aborts it immediately: the buffer is discarded, no further write occurs, and no ap_done is generated.
REQ-033 After reset deassertion, the block waits for a new ap_start.

Verification
REQ-034 MEM_SIZE=4, REPEAT=2, ROM={10,20,30,40}, full_n=1 -> din sequence 10,20,30,40,10,20,30,40 on 8 consecutive write cycles; ap_done pulses once, one cycle after the last transfer.
REQ-035 Same configuration, full_n=0 for 5 cycles starting at the 3rd transfer -> din holds 30 with write=1 throughout the stall; no word is skipped or duplicated; bias_ce is low once the buffer holds 2 entries.
REQ-036 MEM_SIZE=1, REPEAT=3, ROM={7} -> exactly three transfers of 7, bias_address constant 0, one ap_done pulse.
REQ-037 ap_start held high for the whole sequence -> exactly one sequence runs; ap_idle returns to 1 after DONE; a second sequence starts only on the next IDLE cycle with ap_start=1.
REQ-038 ap_rst pulsed after 3 transfers -> write=0 and ce=0 immediately; no ap_done; a fresh ap_start restarts from address 0 with din=10.
REQ-039 Random full_n toggling, MEM_SIZE=16, REPEAT=4 -> the scoreboard sees 64 ordered words; write is never asserted with an empty buffer.

Source files
------------

// File: rtl/bias_seq_ctrl.sv
// Bias ROM sequencer: streams MEM_SIZE bias words REPEAT times into a downstream
// FIFO, through a 2-entry skid buffer that absorbs the one-cycle ROM read latency.
`ifndef COEFF_WIDTH
`define COEFF_WIDTH 16
`endif

module bias_seq_ctrl #(
  parameter int unsigned MEM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = `COEFF_WIDTH,
  parameter int unsigned REPEAT     = 4,
  localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
  localparam int unsigned PW = ($clog2(REPEAT + 1) > 1) ? $clog2(REPEAT + 1) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic [AW-1:0]         bias_address,
  output logic                  bias_ce,
  input  logic [DATA_WIDTH-1:0] bias_q,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_SIZE - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(REPEAT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_addr;
  logic [PW-1:0]         r_pass;
  logic                  r_inflight;
  logic [1:0]            r_cnt;
  logic                  r_rptr;
  logic                  r_wptr;
  logic [DATA_WIDTH-1:0] r_buf [2];

  logic                  w_pop;
  logic                  w_ce;
  logic                  w_wrap;
  logic                  w_last_rd;
  logic [2:0]            w_occ;

  always_comb begin
    output_V_write = (r_cnt != 2'd0);
    w_pop          = output_V_write & output_V_full_n;
    // Occupancy is credited with this cycle's pop so a read can be issued every
    // cycle while the consumer keeps up; a stalled consumer gets no credit.
    w_occ          = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_ce           = (r_state == S_RUN) && (w_occ < 3'd2);
    w_wrap         = (r_addr == LAST_ADDR);
    w_last_rd      = w_ce && w_wrap && (r_pass == LAST_PASS);
    bias_ce        = w_ce;
    bias_address   = r_addr;
    output_V_din   = r_buf[r_rptr];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    ap_idle = 1'b0;
    ap_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_rd) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_inflight && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop))) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        ap_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_addr     <= '0;
      r_pass     <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
      r_rptr     <= 1'b0;
      r_wptr     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_inflight <= w_ce;

      if ((r_state == S_IDLE) && ap_start) begin
        r_addr <= '0;
        r_pass <= '0;
      end else if (w_ce) begin
        if (w_wrap) begin
          r_addr <= '0;
          r_pass <= r_pass + PW'(1);
        end else begin
          r_addr <= r_addr + AW'(1);
        end
      end

      // ROM data returns the cycle after its read was issued.
      if (r_inflight) begin
        r_buf[r_wptr] <= bias_q;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end

      case ({r_inflight, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Self-checking bench for bias_seq_ctrl: three configurations, a per-instance
// scoreboard of expected words, a cycle table for the stall case, and directed runs.
`timescale 1ns/1ps

module tb_bias_seq_ctrl;

  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          start_a, idle_a, done_a, ce_a, fn_a, wr_a;
  logic [1:0]    addr_a;
  logic [DW-1:0] rq_a, din_a;

  logic          start_b, idle_b, done_b, ce_b, fn_b, wr_b;
  logic [0:0]    addr_b;
  logic [DW-1:0] rq_b, din_b;

  logic          start_c, idle_c, done_c, ce_c, fn_c, wr_c;
  logic [3:0]    addr_c;
  logic [DW-1:0] rq_c, din_c;

  logic [DW-1:0] rom_a [4];
  logic [DW-1:0] rom_c [16];

  logic [DW-1:0] sb_a[$];
  logic [DW-1:0] sb_b[$];
  logic [DW-1:0] sb_c[$];

  int n_cmp = 0;
  int n_err = 0;

  bias_seq_ctrl #(.MEM_SIZE(4), .DATA_WIDTH(DW), .REPEAT(2)) u_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .ap_idle(idle_a), .ap_done(done_a),
    .bias_address(addr_a), .bias_ce(ce_a), .bias_q(rq_a),
    .output_V_din(din_a), .output_V_full_n(fn_a), .output_V_write(wr_a)
  );

  bias_seq_ctrl #(.MEM_SIZE(1), .DATA_WIDTH(DW), .REPEAT(3)) u_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .ap_idle(idle_b), .ap_done(done_b),
    .bias_address(addr_b), .bias_ce(ce_b), .bias_q(rq_b),
    .output_V_din(din_b), .output_V_full_n(fn_b), .output_V_write(wr_b)
  );

  bias_seq_ctrl #(.MEM_SIZE(16), .DATA_WIDTH(DW), .REPEAT(4)) u_c (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_c), .ap_idle(idle_c), .ap_done(done_c),
    .bias_address(addr_c), .bias_ce(ce_c), .bias_q(rq_c),
    .output_V_din(din_c), .output_V_full_n(fn_c), .output_V_write(wr_c)
  );

  // Synchronous ROM models: data valid one cycle after ce.
  always_ff @(posedge clk) begin
    if (ce_a) rq_a <= rom_a[addr_a];
    if (ce_b) rq_b <= 16'd7;
    if (ce_c) rq_c <= rom_c[addr_c];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Scoreboard monitor: every write cycle must present the expected head word.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_a) begin
        if (sb_a.size() == 0) flag("a_write_with_nothing_expected");
        else begin
          chk("a_din", din_a, sb_a[0]);
          if (fn_a) void'(sb_a.pop_front());
        end
      end
      if (wr_b) begin
        if (sb_b.size() == 0) flag("b_write_with_nothing_expected");
        else begin
          chk("b_din", din_b, sb_b[0]);
          if (fn_b) void'(sb_b.pop_front());
        end
      end
      if (wr_c) begin
        if (sb_c.size() == 0) flag("c_write_with_nothing_expected");
        else begin
          chk("c_din", din_c, sb_c[0]);
          if (fn_c) void'(sb_c.pop_front());
        end
      end
      if (ce_b) chk("b_addr_const", {31'd0, addr_b}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) sb_a.push_back(rom_a[i % 4]);
  endtask

  task automatic wait_done_a(input string name, input int budget);
    int got;
    got = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_a) begin
        got = 1;
        break;
      end
    end
    chk(name, got, 1);
  endtask

  task automatic test_free_run;
    int first, last, nx, nd, dk;
    first = -1; last = -1; nx = 0; nd = 0; dk = -1;
    @(posedge clk); #1 start_a = 1'b1; push_a(8);
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wr_a && fn_a) begin
        if (first < 0) first = k;
        last = k;
        nx++;
      end
      if (done_a) begin
        nd++;
        dk = k;
      end
    end
    chk("free_first_write_cycle", first, 2);
    chk("free_last_write_cycle", last, 9);
    chk("free_transfers", nx, 8);
    chk("free_done_count", nd, 1);
    chk("free_done_cycle", dk, 10);
    chk("free_idle_after", idle_a, 1);
    chk("free_sb_empty", sb_a.size(), 0);
  endtask

  typedef struct {
    logic          start;
    logic          full_n;
    logic          idle;
    logic          ce;
    logic          wr;
    logic [DW-1:0] din;
    logic          done;
  } vec_t;

  task automatic test_stall_table;
    vec_t tbl[18];
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,  1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd10, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd20, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd30, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd40, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd10, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd20, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd30, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd40, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0,  1'b1};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0,  1'b0};
    for (int r = 0; r < 18; r++) begin
      @(posedge clk);
      #1;
      start_a = tbl[r].start;
      fn_a    = tbl[r].full_n;
      if (tbl[r].start) push_a(8);
      @(negedge clk);
      chk($sformatf("tbl%0d_idle", r), idle_a, tbl[r].idle);
      chk($sformatf("tbl%0d_ce", r), ce_a, tbl[r].ce);
      chk($sformatf("tbl%0d_write", r), wr_a, tbl[r].wr);
      chk($sformatf("tbl%0d_done", r), done_a, tbl[r].done);
      if (tbl[r].wr) chk($sformatf("tbl%0d_din", r), din_a, tbl[r].din);
    end
    fn_a = 1'b1;
    chk("tbl_sb_empty", sb_a.size(), 0);
  endtask

  task automatic test_hold_start;
    int nd;
    nd = 0;
    @(posedge clk); #1 start_a = 1'b1; push_a(16);
    for (int k = -1; k <= 10; k++) begin
      @(negedge clk);
      if (done_a) nd++;
    end
    chk("hold_done_once", nd, 1);
    @(negedge clk);
    chk("hold_idle_after_done", idle_a, 1);
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    chk("hold_restart_from_idle", idle_a, 0);
    wait_done_a("hold_second_done", 40);
    @(negedge clk);
    chk("hold_sb_empty", sb_a.size(), 0);
  endtask

  task automatic test_reset_abort;
    int nx, nw, nd;
    nx = 0; nw = 0; nd = 0;
    @(posedge clk); #1 start_a = 1'b1; push_a(8);
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 0; k < 20 && nx < 3; k++) begin
      @(negedge clk);
      if (wr_a && fn_a) nx++;
    end
    chk("rst_saw_three_transfers", nx, 3);
    #2 rst = 1'b1;
    #1;
    chk("rst_write_low", wr_a, 0);
    chk("rst_ce_low", ce_a, 0);
    chk("rst_done_low", done_a, 0);
    chk("rst_din_zero", din_a, 0);
    chk("rst_idle_high", idle_a, 1);
    sb_a.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_a) nw++;
      if (done_a) nd++;
    end
    chk("rst_no_write_after", nw, 0);
    chk("rst_no_done_after", nd, 0);
    @(posedge clk); #1 start_a = 1'b1; push_a(8);
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    chk("rst_restart_ce", ce_a, 1);
    chk("rst_restart_addr0", addr_a, 0);
    wait_done_a("rst_restart_done", 40);
    chk("rst_restart_sb_empty", sb_a.size(), 0);
  endtask

  task automatic test_single_word;
    int nx, nd;
    nx = 0; nd = 0;
    @(posedge clk); #1 start_b = 1'b1;
    for (int i = 0; i < 3; i++) sb_b.push_back(16'd7);
    @(posedge clk); #1 start_b = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (wr_b && fn_b) nx++;
      if (done_b) nd++;
    end
    chk("b_transfers", nx, 3);
    chk("b_done_count", nd, 1);
    chk("b_sb_empty", sb_b.size(), 0);
    chk("b_idle_after", idle_b, 1);
  endtask

  task automatic test_random_backpressure;
    int nx, got;
    nx = 0; got = 0;
    @(posedge clk); #1 start_c = 1'b1;
    for (int i = 0; i < 64; i++) sb_c.push_back(rom_c[i % 16]);
    @(posedge clk); #1 start_c = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1 fn_c = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (wr_c && fn_c) nx++;
      if (done_c) begin
        got = 1;
        break;
      end
    end
    fn_c = 1'b1;
    chk("c_done_seen", got, 1);
    chk("c_transfers", nx, 64);
    chk("c_sb_empty", sb_c.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    fn_a = 1'b1; fn_b = 1'b1; fn_c = 1'b1;
    rom_a[0] = 16'd10; rom_a[1] = 16'd20; rom_a[2] = 16'd30; rom_a[3] = 16'd40;
    for (int i = 0; i < 16; i++) rom_c[i] = 16'(i * 3 + 5);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_idle_a", idle_a, 1);
    chk("reset_done_a", done_a, 0);
    chk("reset_ce_a", ce_a, 0);
    chk("reset_write_a", wr_a, 0);
    chk("reset_din_a", din_a, 0);
    chk("reset_addr_a", addr_a, 0);
    chk("reset_idle_c", idle_c, 1);
    chk("reset_write_c", wr_c, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_still_idle", idle_a, 1);
    chk("post_reset_no_write", wr_a, 0);

    test_free_run();
    test_stall_table();
    test_hold_start();
    test_reset_abort();
    test_single_word();
    test_random_backpressure();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
